hamming127_serial_encoder: RTL and testbench



---
 rtl/ham_pkg.sv | 32 +++
 rtl/ham_lfsr7.sv | 40 ++++
 rtl/hamming127_serial_encoder.sv | 174 +++++++++++++++++
 tb/tb_hamming127_serial_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// ham_pkg: constants and state type shared by the serial Hamming(127,120) encoder.
//   N          codeword length (127, or 128 with the overall parity bit)
//   K          message length
//   NUM_PARITY Hamming parity bit count
//   GEN_POLY   g6..g0 of g(x) = x^7 + x^3 + 1 (x^7 implicit)
//   CNT_W      bit index width
// Optional feature macro: EXT_PARITY_EN (extended Hamming(128,120) SECDED).
package ham_pkg;

`ifdef EXT_PARITY_EN
    localparam int unsigned N = 128;
`else
    localparam int unsigned N = 127;
`endif
    localparam int unsigned K          = 120;
    localparam int unsigned NUM_PARITY = 7;
    localparam int unsigned N_HAM      = K + NUM_PARITY;
    localparam logic [NUM_PARITY-1:0] GEN_POLY = 7'b0001001;
    localparam int unsigned CNT_W      = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
`ifdef EXT_PARITY_EN
        PARITY,
        EXTP
`else
        PARITY
`endif
    } enc_state_t;

endpackage

// File: rtl/ham_lfsr7.sv
// ham_lfsr7: division LFSR for g(x) = x^7 + x^3 + 1.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear of the remainder (wins over shift)
//   shift        advance one bit
//   feedback_en  1: divide (feedback = din ^ msb); 0: plain shift-out
//   din          message bit, highest degree first
//   msb          remainder bit 6 (next parity bit to emit)
//   remainder    full 7-bit remainder r6..r0
module ham_lfsr7
    import ham_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  shift,
    input  logic                  feedback_en,
    input  logic                  din,
    output logic                  msb,
    output logic [NUM_PARITY-1:0] remainder
);

    logic [NUM_PARITY-1:0] r;
    logic                  fb;

    assign fb = feedback_en & (din ^ r[NUM_PARITY-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (shift) begin
            r <= {r[NUM_PARITY-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
    end

    assign msb       = r[NUM_PARITY-1];
    assign remainder = r;

endmodule

// File: rtl/hamming127_serial_encoder.sv
// hamming127_serial_encoder: serial systematic Hamming(127,120) encoder.
// Takes 120 message bits on a din/din_valid/din_ready handshake and emits
// the codeword on dout: the data bits echoed, then 7 parity bits back-to-back.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begins a frame (IDLE only)
//   abort        drops the frame, back to IDLE (beats start)
//   din          message bit, MSB first; din_valid qualifies it
//   din_ready    high in DATA
//   dout         codeword bit; dout_valid qualifies it (no backpressure)
//   bit_idx      index of the bit on dout
//   frame_done   one-cycle pulse with the last codeword bit
//   busy         state != IDLE
// Macro EXT_PARITY_EN: appends an overall even-parity bit (N = 128).
module hamming127_serial_encoder
    import ham_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] bit_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] LAST_HAM  = CNT_W'(N_HAM - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);

    enc_state_t state, state_n;
    logic [CNT_W-1:0] cnt;

    logic frame_clear;
    logic lfsr_shift;
    logic lfsr_fb_en;
    logic cnt_inc;
    logic emit;
    logic emit_bit;

    logic                  lfsr_msb;
    logic [NUM_PARITY-1:0] lfsr_rem;

`ifdef EXT_PARITY_EN
    logic ovp;
`endif

    ham_lfsr7 u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (frame_clear),
        .shift       (lfsr_shift),
        .feedback_en (lfsr_fb_en),
        .din         (din),
        .msb         (lfsr_msb),
        .remainder   (lfsr_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        frame_clear = 1'b0;
        lfsr_shift  = 1'b0;
        lfsr_fb_en  = 1'b0;
        cnt_inc     = 1'b0;
        emit        = 1'b0;
        emit_bit    = 1'b0;

        if (abort) begin
            state_n     = IDLE;
            frame_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n     = DATA;
                        frame_clear = 1'b1;
                    end
                end
                DATA: begin
                    if (din_valid) begin
                        lfsr_shift = 1'b1;
                        lfsr_fb_en = 1'b1;
                        cnt_inc    = 1'b1;
                        emit       = 1'b1;
                        emit_bit   = din;
                        if (cnt == LAST_DATA) begin
                            state_n = PARITY;
                        end
                    end
                end
                PARITY: begin
                    lfsr_shift = 1'b1;
                    cnt_inc    = 1'b1;
                    emit       = 1'b1;
                    emit_bit   = lfsr_msb;
                    if (cnt == LAST_HAM) begin
`ifdef EXT_PARITY_EN
                        state_n = EXTP;
`else
                        state_n = IDLE;
`endif
                    end
                end
`ifdef EXT_PARITY_EN
                EXTP: begin
                    cnt_inc  = 1'b1;
                    emit     = 1'b1;
                    emit_bit = ovp;
                    state_n  = IDLE;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (frame_clear) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef EXT_PARITY_EN
    // Running XOR of every emitted bit; by the EXTP cycle it covers all 127.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovp <= 1'b0;
        end else if (frame_clear) begin
            ovp <= 1'b0;
        end else if (emit) begin
            ovp <= ovp ^ emit_bit;
        end
    end
`endif

    // Output stage: everything seen on dout lags the accept/emission by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            dout       <= emit ? emit_bit : 1'b0;
            dout_valid <= emit;
            bit_idx    <= emit ? cnt : '0;
            frame_done <= emit && (cnt == LAST_IDX);
        end
    end

    assign din_ready = (state == DATA);
    assign busy      = (state != IDLE);

    // By the last parity shift the remainder has been shifted out down to r0.
    lfsr_drained: assert property (@(posedge clk) disable iff (!rst_n)
        (state == PARITY && cnt == LAST_HAM) |-> (lfsr_rem[NUM_PARITY-2:0] == '0));

endmodule

// File: tb/tb_hamming127_serial_encoder.sv
module tb_hamming127_serial_encoder;

`ifdef EXT_PARITY_EN
    localparam int CW_LEN = 128;
`else
    localparam int CW_LEN = 127;
`endif

    typedef struct packed {
        logic [7:0] idx;
        logic       b;
        logic       fd;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       dout_valid;
    logic [7:0] bit_idx;
    logic       frame_done;
    logic       busy;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    hamming127_serial_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: long division of m(x)*x^7 by x^7+x^3+1 (0x89).
    function automatic logic [6:0] ref_parity(input logic [119:0] m);
        logic [126:0] p;
        p = '0;
        for (int i = 0; i < 120; i++) p[126-i] = m[i];
        for (int d = 126; d >= 7; d--)
            if (p[d]) p[d -: 8] = p[d -: 8] ^ 8'h89;
        return p[6:0];
    endfunction

    // Monitor: pops one expected entry per valid output beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dout_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_valid", {24'd0, bit_idx}, 32'hFFFF);
                    end else begin
                        e = q.pop_front();
                        check("bit_idx", {24'd0, bit_idx}, {24'd0, e.idx});
                        check("dout", {31'd0, dout}, {31'd0, e.b});
                        check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                    end
                end else if (frame_done) begin
                    check("fd_without_valid", {31'd0, frame_done}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks begin and end 1ns after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [119:0] m, input bit gaps, input bit poke_start,
                        input int stop_at);
        int i   = 0;
        int cyc = 0;
        logic v;
        while (i < stop_at && cyc < 2000) begin
            v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            din_valid = v;
            din       = m[i];
            start     = poke_start && ($urandom_range(0, 3) == 0);
            check("din_ready_data", {31'd0, din_ready}, 32'd1);
            if (v && din_ready) begin
                q.push_back('{idx: 8'(i), b: m[i], fd: 1'b0});
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        din_valid = 1'b0;
        start     = 1'b0;
        if (i < stop_at) check("feed_timeout", i, stop_at);
    endtask

    task automatic push_parity(input logic [119:0] m, input logic [6:0] par);
        for (int j = 0; j < 7; j++)
            q.push_back('{idx: 8'(120 + j), b: par[6-j], fd: (120 + j == CW_LEN - 1)});
`ifdef EXT_PARITY_EN
        q.push_back('{idx: 8'd127, b: (^m) ^ (^par), fd: 1'b1});
`endif
    endtask

    // From bit 119 to the end, dout_valid must stay high with din_ready low.
    task automatic check_burst();
        for (int k = 0; k < CW_LEN - 119; k++) begin
            @(negedge clk);
            check("burst_valid", {31'd0, dout_valid}, 32'd1);
            check("burst_ready", {31'd0, din_ready}, 32'd0);
        end
        @(negedge clk);
        check("post_valid", {31'd0, dout_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("drain", q.size(), 0);
    endtask

    task automatic full_frame(input logic [119:0] m, input logic [6:0] par,
                              input bit gaps, input bit poke_start);
        do_start();
        feed(m, gaps, poke_start, 120);
        push_parity(m, par);
        check_burst();
    endtask

    initial begin
        logic [119:0] m;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; din = 1'b0; din_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_dout", {31'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_idx", {24'd0, bit_idx}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, din_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero message.
        full_frame('0, 7'b0000000, 1'b0, 1'b0);

        // Only bit 119 set: r = x^3 + 1.
        m = '0; m[119] = 1'b1;
        full_frame(m, 7'b0001001, 1'b0, 1'b0);

        // Only bit 113 set (x^6): r = x^6 + x^5 + x^2.
        m = '0; m[113] = 1'b1;
        full_frame(m, 7'b1100100, 1'b0, 1'b0);

        // Random message, gapped valid, stray start pulses.
        m = {$urandom(), $urandom(), $urandom(), 24'($urandom())};
        full_frame(m, ref_parity(m), 1'b1, 1'b1);

        // Abort at bit 60.
        do_start();
        feed('1, 1'b0, 1'b0, 60);
        abort = 1'b1; din_valid = 1'b1; din = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; din_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("abort_drain", q.size(), 0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, dout_valid}, 32'd0);

        // Abort and start together in IDLE: stay idle.
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", {31'd0, busy}, 32'd0);

        // New frame after abort starts from a cleared LFSR.
        m = '0; m[119] = 1'b1;
        full_frame(m, 7'b0001001, 1'b0, 1'b0);

        // Reset while bit 124 is on dout.
        m = {$urandom(), $urandom(), $urandom(), 24'($urandom())};
        do_start();
        feed(m, 1'b0, 1'b0, 120);
        push_parity(m, ref_parity(m));
        repeat (5) @(posedge clk); #1;
        check("pre_rst_idx", {24'd0, bit_idx}, 32'd124);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", {31'd0, dout}, 32'd0);
        check("midrst_valid", {31'd0, dout_valid}, 32'd0);
        check("midrst_idx", {24'd0, bit_idx}, 32'd0);
        check("midrst_fd", {31'd0, frame_done}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        q.delete();
        repeat (3) @(posedge clk); #1;
        check("midrst_hold_valid", {31'd0, dout_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame after reset.
        m = '0; m[113] = 1'b1;
        full_frame(m, 7'b1100100, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
